// File: rtl/q_hist_display.sv
// 4-deep Q capture history scanned onto a multiplexed active-low 4-digit 7-segment display.
// Build option BLANK_INVALID_EN: invalid slots are blank instead of showing a dash.
module q_hist_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] Q_IN,
  input  logic       Q_VALID,
  input  logic       STB,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       DP
);

  localparam logic [15:0] P_LAST = 16'(SCAN_DIV - 1);

`ifdef BLANK_INVALID_EN
  localparam logic [6:0] INVALID_GLYPH = 7'b1111111;
`else
  localparam logic [6:0] INVALID_GLYPH = 7'b0111111;
`endif

  logic [3:0][3:0] h_q, h_d;
  logic [3:0]      v_q, v_d;
  logic [15:0]     p_q, p_d;
  logic [1:0]      d_q, d_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic [3:0]      wrap;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // A wrap pairs a slot with its older neighbour; both must hold real values.
  always_comb begin
    wrap = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      wrap[i] = v_q[i] && v_q[i+1] &&
                (({h_q[i], h_q[i+1]} == 8'h0F) || ({h_q[i], h_q[i+1]} == 8'hF0));
    end
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (STB) begin
      h_d = {h_q[2:0], (Q_VALID ? Q_IN : 4'h0)};
      v_d = {v_q[2:0], Q_VALID};
    end
    p_d   = (p_q == P_LAST) ? 16'd0 : p_q + 16'd1;
    d_d   = (p_q == P_LAST) ? d_q + 2'd1 : d_q;
    an_d  = ~(4'b0001 << d_q);
    seg_d = v_q[d_q] ? hex7(h_q[d_q]) : INVALID_GLYPH;
    dp_d  = ~wrap[d_q];
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      h_q   <= '0;
      v_q   <= 4'b0000;
      p_q   <= 16'd0;
      d_q   <= 2'd0;
      seg_q <= 7'b1111111;
      an_q  <= 4'b1111;
      dp_q  <= 1'b1;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      p_q   <= p_d;
      d_q   <= d_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_q_hist_display.sv
// Self-checking bench for q_hist_display: cycle model of the history/scan plus directed literal checks.
module tb_q_hist_display;

  localparam int SCAN_DIV = 4;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] Q_IN;
  logic       Q_VALID;
  logic       STB;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       DP;

  q_hist_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .CLR(CLR), .Q_IN(Q_IN), .Q_VALID(Q_VALID), .STB(STB),
    .SEG(SEG), .AN(AN), .DP(DP)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Glyphs described by their lit segment letters, converted to active-low {g..a}.
  function automatic int glyph(input string lit);
    int m = 7'h7F;
    for (int i = 0; i < lit.len(); i++) m = m & ~(1 << (int'(lit[i]) - 97));
    return m;
  endfunction

  function automatic int hex_glyph(input int v);
    string tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    return glyph(tbl[v]);
  endfunction

`ifdef BLANK_INVALID_EN
  int invalid_glyph = 7'h7F;
`else
  int invalid_glyph = 7'h3F;
`endif

  // Model: edges since reset release select the digit; outputs use pre-edge history.
  int cyc = 0;
  int mh [4] = '{0, 0, 0, 0};
  bit mv [4] = '{0, 0, 0, 0};
  int e_seg = 7'h7F, e_an = 4'hF, e_dp = 1;

  always @(posedge CLK) begin
    if (CLR) begin
      cyc = 0;
      mh = '{0, 0, 0, 0};
      mv = '{0, 0, 0, 0};
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1;
    end else begin
      int d;
      bit w;
      d = (cyc / SCAN_DIV) % 4;
      e_an  = 15 - (1 << d);
      e_seg = mv[d] ? hex_glyph(mh[d]) : invalid_glyph;
      w = 0;
      if (d < 3 && mv[d] && mv[d+1])
        w = (mh[d] == 0 && mh[d+1] == 15) || (mh[d] == 15 && mh[d+1] == 0);
      e_dp = w ? 0 : 1;
      cyc++;
      if (STB) begin
        for (int i = 3; i > 0; i--) begin mh[i] = mh[i-1]; mv[i] = mv[i-1]; end
        mh[0] = Q_VALID ? int'(Q_IN) : 0;
        mv[0] = Q_VALID;
      end
    end
  end

  always @(negedge CLK) begin
    chk("model_seg", int'(SEG), e_seg);
    chk("model_an",  int'(AN),  e_an);
    chk("model_dp",  int'(DP),  e_dp);
  end

  task automatic wait_an(input logic [3:0] a);
    bit hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge CLK);
      if (AN == a) hit = 1;
    end
    if (!hit) chk("wait_an_timeout", 0, int'(a));
  endtask

  initial begin
    CLR = 1'b1; STB = 1'b0; Q_IN = 4'h0; Q_VALID = 1'b0;
    #1;
    chk("reset_an",  int'(AN),  4'hF);
    chk("reset_seg", int'(SEG), 7'h7F);
    chk("reset_dp",  int'(DP),  1);
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    chk("release_an",  int'(AN),  4'b1110);
    chk("release_seg", int'(SEG), 7'b0111111 & invalid_glyph | (invalid_glyph == 7'h7F ? 7'h7F : 0));

    // Single capture of 7 while digit 3 is selected.
    wait_an(4'b0111);
    STB = 1'b1; Q_IN = 4'h7; Q_VALID = 1'b1;
    @(negedge CLK);
    STB = 1'b0;
    wait_an(4'b1110);
    chk("seven_seg", int'(SEG), 7'b1111000);

    // Captures E, F, 0, 1 -> wrap between H1=0 and H2=F.
    STB = 1'b1; Q_IN = 4'hE;
    @(negedge CLK); Q_IN = 4'hF;
    @(negedge CLK); Q_IN = 4'h0;
    @(negedge CLK); Q_IN = 4'h1;
    @(negedge CLK); STB = 1'b0;
    wait_an(4'b1110);
    chk("wrap_d0_seg", int'(SEG), 7'b1111001);
    chk("wrap_d0_dp",  int'(DP),  1);
    wait_an(4'b1101);
    chk("wrap_d1_dp",  int'(DP),  0);
    chk("wrap_d1_seg", int'(SEG), 7'b1000000);
    wait_an(4'b1011);
    chk("wrap_d2_dp",  int'(DP),  1);

    // Valid F followed by an invalid capture with the bus still at F.
    STB = 1'b1; Q_IN = 4'hF; Q_VALID = 1'b1;
    @(negedge CLK); Q_VALID = 1'b0;
    @(negedge CLK); STB = 1'b0;
    wait_an(4'b1110);
    chk("invalid_seg", int'(SEG), invalid_glyph);
    chk("invalid_dp",  int'(DP),  1);
    wait_an(4'b1101);
    chk("invalid_nbr_seg", int'(SEG), 7'b0001110);

    // Asynchronous clear mid-frame on digit 2, with a capture during reset.
    wait_an(4'b1011);
    #2 CLR = 1'b1;
    #1;
    chk("async_clr_an",  int'(AN),  4'hF);
    chk("async_clr_seg", int'(SEG), 7'h7F);
    chk("async_clr_dp",  int'(DP),  1);
    @(negedge CLK);
    STB = 1'b1; Q_IN = 4'h5; Q_VALID = 1'b1;
    @(negedge CLK);
    STB = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    chk("clr_release_an",  int'(AN),  4'b1110);
    chk("clr_release_seg", int'(SEG), invalid_glyph);

    // Capture on the terminal prescaler cycle of digit 3.
    wait_an(4'b0111);
    repeat (2) @(negedge CLK);
    STB = 1'b1; Q_IN = 4'hA; Q_VALID = 1'b1;
    @(negedge CLK);
    STB = 1'b0;
    @(negedge CLK);
    chk("term_an",  int'(AN),  4'b1110);
    chk("term_seg", int'(SEG), 7'b0001000);

    repeat (20) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
